// File: rtl/br_seq.sv
// Control-step sequencer for SRC br/brl: walks the datapath through the link,
// condition-evaluate and target steps, and gates the PC load with con_out.
module br_seq #(
    parameter int w     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [w-1:0]     IR,
    input  logic             hold,
    input  logic             con_out,
    output logic             con_in,
    output logic             gra,
    output logic             grb,
    output logic             grc,
    output logic             r_out,
    output logic             r_in,
    output logic             pc_out,
    output logic             pc_in,
    output logic             busy,
    output logic             done,
    output logic             taken,
    output logic             err,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LINK   = 3'd1,
        S_COND   = 3'd2,
        S_TARGET = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    localparam logic [4:0] OP_BR  = 5'd8;
    localparam logic [4:0] OP_BRL = 5'd9;

    state_t     state;
    logic [2:0] c3_q;
    logic       taken_q;
    logic       err_q;
    logic       take_now;
    logic [4:0] op;

    // The register file decodes ra/rb/rc itself; only op and c3 matter here.
    logic unused_ir;
    assign unused_ir = ^IR[26:3];

    assign op       = IR[31:27];
    // c3 of 6 or 7 means "never", whatever the condition unit latched.
    assign take_now = con_out & (c3_q <= 3'd5);

    // Sequencing and bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            c3_q      <= 3'd0;
            taken_q   <= 1'b0;
            err_q     <= 1'b0;
            taken_cnt <= '0;
        end else if (!hold) begin
            // A pending err survives a hold and is shown on the first free cycle.
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op == OP_BR) begin
                            c3_q  <= IR[2:0];
                            state <= S_COND;
                        end else if (op == OP_BRL) begin
                            c3_q  <= IR[2:0];
                            state <= S_LINK;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_LINK:   state <= S_COND;
                S_COND:   state <= S_TARGET;
                S_TARGET: begin
                    taken_q <= take_now;
                    state   <= S_FIN;
                end
                S_FIN: begin
                    if (taken_q && (taken_cnt != {CNT_W{1'b1}}))
                        taken_cnt <= taken_cnt + 1'b1;
                    taken_q <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Moore decode; hold masks the strobes but keeps selects and bus enables up.
    always_comb begin
        con_in = 1'b0;
        gra    = 1'b0;
        grb    = 1'b0;
        grc    = 1'b0;
        r_out  = 1'b0;
        r_in   = 1'b0;
        pc_out = 1'b0;
        pc_in  = 1'b0;
        done   = 1'b0;
        taken  = 1'b0;
        case (state)
            S_LINK: begin
                pc_out = 1'b1;
                gra    = 1'b1;
                r_in   = ~hold;
            end
            S_COND: begin
                grc    = 1'b1;
                r_out  = 1'b1;
                con_in = ~hold;
            end
            S_TARGET: begin
                grb   = 1'b1;
                r_out = 1'b1;
                pc_in = take_now & ~hold;
            end
            S_FIN: begin
                done  = ~hold;
                taken = taken_q;
            end
            default: ;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign err       = err_q & ~hold;
    assign dbg_state = state;

endmodule

// File: tb/tb_br_seq.sv
// Self-checking bench for br_seq: directed branch sequences plus a random run,
// with done/taken timing matched against an expected queue.
module tb_br_seq;

    localparam int W_EXP = 33;
    localparam int CNT_W = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LINK   = 3'd1;
    localparam logic [2:0] ST_COND   = 3'd2;
    localparam logic [2:0] ST_TARGET = 3'd3;

    logic clk;
    logic rst;
    logic start;
    logic [31:0] ir;
    logic hold;
    logic con_out;
    logic con_in, gra, grb, grc, r_out, r_in, pc_out, pc_in;
    logic busy, done, taken, err;
    logic [CNT_W-1:0] taken_cnt;
    logic [2:0] dbg_state;

    int n_checks;
    int n_fail;
    int cyc;
    int exp_cnt;
    logic [W_EXP-1:0] exp_q[$];

    br_seq #(.w(32), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .IR(ir), .hold(hold),
        .con_out(con_out), .con_in(con_in), .gra(gra), .grb(grb), .grc(grc),
        .r_out(r_out), .r_in(r_in), .pc_out(pc_out), .pc_in(pc_in),
        .busy(busy), .done(done), .taken(taken), .err(err),
        .taken_cnt(taken_cnt), .dbg_state(dbg_state)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [2:0] c3);
        return {op, 5'd1, 5'd2, 5'd3, 9'd0, c3};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bump_cnt(input logic tk);
        if (tk && exp_cnt < 3) exp_cnt++;
    endtask

    task automatic push_exp(input int lat, input logic tk);
        logic [31:0] t;
        t = cyc + lat;
        exp_q.push_back({t, tk});
    endtask

    // Scoreboard monitor: every done must match the next expected (cycle, taken).
    always @(negedge clk) begin
        logic [W_EXP-1:0] item;
        if (!rst) check("bus_excl", {31'd0, r_out & pc_out}, 32'd0);
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                item = exp_q.pop_front();
                check("done_cycle", cyc, item[32:1]);
                check("done_taken", {31'd0, taken}, {31'd0, item[0]});
            end
        end
    end

    // One full branch with no hold; IR is scrambled after start.
    task automatic run_branch(input logic [4:0] op, input logic [2:0] c3, input logic con);
        logic tk;
        int n;
        tk = con && (c3 <= 3'd5);
        n  = (op == 5'd9) ? 4 : 3;
        start = 1'b1; ir = mk_ir(op, c3); con_out = con;
        push_exp(n, tk);
        step();
        start = 1'b0; ir = $urandom;
        for (int k = 1; k < n; k++) begin
            #1;
            if (k == n - 1) check("target_pc_in", {31'd0, pc_in}, {31'd0, tk});
            if (k == 1 && n == 4) check("link_state", {29'd0, dbg_state}, {29'd0, ST_LINK});
            step();
        end
        #1 check("fin_done", {31'd0, done}, 32'd1);
        step();
        bump_cnt(tk);
        #1 check("cnt_after", {30'd0, taken_cnt}, exp_cnt);
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; exp_cnt = 0;
        rst = 1'b1; start = 1'b0; ir = 32'd0; hold = 1'b0; con_out = 1'b0;
        #1;
        check("reset_outs", {20'd0, con_in, gra, grb, grc, r_out, r_in, pc_out, pc_in,
                             busy, done, taken, err}, 32'd0);
        check("reset_cnt", {30'd0, taken_cnt}, 32'd0);
        step(); step();
        rst = 1'b0;
        step();

        // br, c3=2, condition true.
        start = 1'b1; ir = mk_ir(5'd8, 3'd2); con_out = 1'b1;
        push_exp(3, 1'b1);
        step();
        start = 1'b0; ir = mk_ir(5'd9, 3'd7);
        #1 check("c1_cond_strobes", {29'd0, con_in, grc, r_out}, 32'd7);
        check("c1_busy", {31'd0, busy}, 32'd1);
        step();
        #1 check("c2_pc_in", {29'd0, pc_in, grb, r_out}, 32'd7);
        step();
        #1 check("c3_done_taken", {30'd0, done, taken}, 32'd3);
        check("c3_cnt_not_yet", {30'd0, taken_cnt}, 32'd0);
        step();
        bump_cnt(1'b1);
        #1 check("cnt_0_to_1", {30'd0, taken_cnt}, exp_cnt);

        // Not taken: condition false, then c3=7 with con_out forced high.
        run_branch(5'd8, 3'd5, 1'b0);
        run_branch(5'd8, 3'd7, 1'b1);

        // brl, c3=1.
        start = 1'b1; ir = mk_ir(5'd9, 3'd1); con_out = 1'b1;
        push_exp(4, 1'b1);
        step();
        start = 1'b0;
        #1 check("brl_link", {28'd0, pc_out, gra, r_in, r_out}, 32'he);
        step();
        #1 check("brl_cond", {29'd0, dbg_state}, {29'd0, ST_COND});
        step();
        #1 check("brl_pc_in", {31'd0, pc_in}, 32'd1);
        step();
        #1 check("brl_done", {31'd0, done}, 32'd1);
        step();
        bump_cnt(1'b1);

        // Illegal opcode.
        start = 1'b1; ir = mk_ir(5'd3, 3'd0);
        #1 check("err_c0", {30'd0, err, busy}, 32'd0);
        step();
        start = 1'b0;
        #1 check("err_c1", {30'd0, err, busy}, 32'd2);
        step();
        #1 check("err_c2", {31'd0, err}, 32'd0);

        // Illegal opcode with hold in cycle 1: err waits for release.
        start = 1'b1; ir = mk_ir(5'd3, 3'd0);
        step();
        start = 1'b0; hold = 1'b1;
        #1 check("err_held", {31'd0, err}, 32'd0);
        step();
        hold = 1'b0;
        #1 check("err_released", {31'd0, err}, 32'd1);
        step();
        #1 check("err_one_cycle", {31'd0, err}, 32'd0);

        // start while busy is ignored, including in FIN.
        start = 1'b1; ir = mk_ir(5'd8, 3'd0); con_out = 1'b0;
        push_exp(3, 1'b0);
        step();
        ir = mk_ir(5'd3, 3'd0);
        #1 check("busy_start_c1", {28'd0, err, dbg_state}, {28'd0, 1'b0, ST_COND});
        step();
        ir = mk_ir(5'd8, 3'd0);
        #1 check("busy_start_c2", {28'd0, err, dbg_state}, {28'd0, 1'b0, ST_TARGET});
        step();
        ir = mk_ir(5'd9, 3'd0);
        #1 check("busy_start_fin", {31'd0, done}, 32'd1);
        step();
        start = 1'b0;
        #1 check("fin_start_ignored", {31'd0, busy}, 32'd0);
        run_branch(5'd8, 3'd4, 1'b0);

        // Hold for 3 cycles on entering COND.
        start = 1'b1; ir = mk_ir(5'd8, 3'd3); con_out = 1'b1;
        push_exp(6, 1'b1);
        step();
        start = 1'b0; hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 check("hold_cond", {26'd0, dbg_state, con_in, grc, r_out},
                     {26'd0, ST_COND, 3'b011});
            step();
        end
        hold = 1'b0;
        #1 check("hold_release_con_in", {31'd0, con_in}, 32'd1);
        step();
        #1 check("hold_target_pc_in", {31'd0, pc_in}, 32'd1);
        step();
        #1 check("hold_done", {31'd0, done}, 32'd1);
        step();
        bump_cnt(1'b1);
        #1 check("cnt_before_reset", {30'd0, taken_cnt}, exp_cnt);

        // Reset in TARGET aborts the instruction.
        start = 1'b1; ir = mk_ir(5'd8, 3'd0); con_out = 1'b1;
        step();
        start = 1'b0;
        step();
        #1 check("pre_reset_target", {29'd0, dbg_state}, {29'd0, ST_TARGET});
        rst = 1'b1;
        #1;
        check("mid_reset_outs", {20'd0, con_in, gra, grb, grc, r_out, r_in, pc_out, pc_in,
                                 busy, done, taken, err}, 32'd0);
        check("mid_reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        check("mid_reset_cnt", {30'd0, taken_cnt}, 32'd0);
        exp_cnt = 0;
        step();
        rst = 1'b0;
        step(); step();

        // Random branches, counter saturates at all-ones.
        for (int i = 0; i < 10; i++) begin
            run_branch($urandom_range(0, 1) ? 5'd9 : 5'd8,
                       3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) run_branch(5'd8, 3'd0, 1'b1);
        check("cnt_saturated", {30'd0, taken_cnt}, 32'd3);

        step(); step();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/br_seq.md
# br_seq

Control-step sequencer for the SRC branch instructions `br` and `brl`. The main control unit hands it a decoded instruction; it drives the datapath through the link, condition-evaluate and target steps. It strobes the condition unit (`con_in`), then gates the PC load with the condition unit's latched `con_out`. It sits between the main control FSM and the shared 32-bit bus datapath, which holds the register file, PC and condition unit.

## Interface
- `w`, 32, datapath/IR width; fields are fixed SRC positions, so `w` must be 32
- `CNT_W`, 16, width of the taken-branch counter
- `clk`  in  1  system clock, rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request from main control; `IR` valid in the same cycle
- `IR`  in  w  instruction: op=`IR[31:27]`, ra=`IR[26:22]`, rb=`IR[21:17]`, rc=`IR[16:12]`, c3=`IR[2:0]`
- `hold`  in  1  datapath stall; freezes the sequencer
- `con_out`  in  1  latched condition result from the condition unit
- `con_in`  out  1  condition-unit load strobe
- `gra`, `grb`, `grc`  out  1 each  one-hot register-field select for the register file
- `r_out`  out  1  register file drives bus
- `r_in`  out  1  register file loads from bus
- `pc_out`  out  1  PC drives bus
- `pc_in`  out  1  PC loads from bus
- `busy`  out  1  sequencer not idle
- `done`  out  1  one-cycle end-of-instruction pulse
- `taken`  out  1  branch outcome, valid while `done`=1
- `err`  out  1  one-cycle pulse: `start` with an unsupported opcode
- `taken_cnt`  out  CNT_W  saturating count of taken branches

## Operation
- States: IDLE, LINK, COND, TARGET, FIN.
- IDLE
  - On `start` with op=8 (`br`): capture IR, go to COND.
  - On `start` with op=9 (`brl`): capture IR, go to LINK.
  - On `start` with any other op: `err`=1 next cycle, stay IDLE.
- LINK: `pc_out`=1, `gra`=1, `r_in`=1, so R[ra] ← PC, unconditionally. Then go to COND.
- COND: `grc`=1, `r_out`=1, `con_in`=1; the condition unit evaluates R[rc] against c3. Then go to TARGET.
- TARGET: `grb`=1, `r_out`=1, `pc_in` = `con_out` & (captured c3 ≤ 5). c3 = 6 or 7 is treated as "never". Capture `taken` = the same value. Then go to FIN.
- FIN: `done`=1, `taken` held. If taken, `taken_cnt` += 1, saturating at all-ones. Then go to IDLE.
- Datapath controls (`gr*`, `r_out`, `r_in`, `pc_out`, `pc_in`, `con_in`) are Moore outputs decoded from state. All are 0 in IDLE and FIN.
- Only one bus driver may be active in any state: `r_out` and `pc_out` are never both 1.
- Control decodes always use the captured IR; `IR` changing after `start` has no effect.
- `busy` = (state ≠ IDLE).
- `start` while `busy`=1 is ignored: no capture, no `err`.
- `hold`=1:
  - No state transition and no counter update.
  - Strobes `con_in`, `r_in`, `pc_in` are forced to 0.
  - Selects and bus enables (`gr*`, `r_out`, `pc_out`) stay asserted, so the bus stays stable.
  - `done` and `err` are not asserted while `hold`=1; they assert on the first cycle with `hold`=0.
  - In IDLE, `start` is ignored while `hold`=1.

## Timing
- Reset (asynchronous, takes effect immediately): state=IDLE; all outputs 0; `taken_cnt`=0; captured IR=0.
- Reset mid-instruction aborts it. No `done` is issued; the PC and register file are left as the last completed strobe left them.
- `start` is sampled on the rising edge ending cycle 0.
- `br` state sequence:
  - Cycle 1: COND.
  - Cycle 2: TARGET; `pc_in` is asserted in this cycle.
  - Cycle 3: FIN; `done`=1.
  - Latency is 3 cycles to `done`.
- `brl` state sequence:
  - Cycle 1: LINK.
  - Cycle 2: COND.
  - Cycle 3: TARGET.
  - Cycle 4: FIN.
  - Latency is 4 cycles to `done`.
- `con_out` is sampled in TARGET. The condition unit loaded it at the COND→TARGET edge, so it must be valid by then.
- `err` asserts in cycle 1 after an illegal `start`, for exactly one cycle.
- Back-to-back: a `start` in the FIN cycle is ignored. The earliest next accepted `start` is in the cycle after FIN, which is IDLE.
- `taken_cnt` updates on the edge leaving FIN.

## Test plan
- `br`, c3=2, R[rc]=0 (so `con_out`=1 in TARGET) -> COND in cycle 1 with `con_in`=`grc`=`r_out`=1; `pc_in`=1 in cycle 2; `done`=`taken`=1 in cycle 3; `taken_cnt` 0→1.
- `br`, c3=5, R[rc]=1 (so `con_out`=0) -> `pc_in`=0 in TARGET; `done`=1, `taken`=0; `taken_cnt` unchanged. Repeat with c3=7 and `con_out` forced to 1 -> `pc_in`=0, `taken`=0.
- `brl`, c3=1 -> cycle 1 `pc_out`=`gra`=`r_in`=1; cycle 3 `pc_in`=1; `done` in cycle 4. Check `r_out` and `pc_out` are never both 1 in any cycle.
- `start` with op=3 -> `err`=1 for one cycle, `busy` stays 0. Pulse `start` again while a `br` is busy -> ignored, sequence timing unchanged.
- `hold`=1 for 3 cycles entering COND -> state frozen, `con_in`=0 while held with `grc`/`r_out` still 1; `con_in`=1 on release; total latency to `done` is 6.
- Assert `rst` in TARGET -> all outputs 0 immediately, no `done`, `taken_cnt`=0. Separately, preload via 2^16 taken branches (or reduce `CNT_W` to 2) -> counter saturates at all-ones.
